bcd_seg_counter: RTL and testbench

//  Upstream feeder of the 4-digit 7-segment multiplexer. Takes three raw push-buttons (up, down, clear)
//  and conditions them: synchronise, debounce, rising-edge detect. Keeps a 4-digit BCD counter (0000..9999).

---
 rtl/seg_pkg.sv | 24 ++
 rtl/bcd_seg_counter_if.sv | 23 ++
 rtl/button_conditioner.sv | 54 +++++
 rtl/bcd_seg_counter.sv | 96 +++++++++
 tb/tb_bcd_seg_counter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment encoding (active-low, dp in bit 7) and BCD digit type,
// used by the counter here and by the downstream display multiplexer.
package seg_pkg;

  typedef logic [3:0] bcd4_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Any nibble above 9 comes out blank rather than as a garbage pattern.
  function automatic logic [7:0] seg_encode(input bcd4_t d);
    logic [7:0] s;
    s = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (d == bcd4_t'(i)) s = SEG_DIGIT[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/bcd_seg_counter_if.sv
// Button inputs and display-side outputs of the BCD segment counter.
// master = button/display side, slave = the counter itself.
interface bcd_seg_counter_if;
  logic        UpB;
  logic        DownB;
  logic        ClrB;
  logic [7:0]  seg0;
  logic [7:0]  seg1;
  logic [7:0]  seg2;
  logic [7:0]  seg3;
  logic [15:0] Count;
  logic        start;

  modport master (
    output UpB, DownB, ClrB,
    input  seg0, seg1, seg2, seg3, Count, start
  );

  modport slave (
    input  UpB, DownB, ClrB,
    output seg0, seg1, seg2, seg3, Count, start
  );
endinterface

// File: rtl/button_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-flop synchroniser,
// counter-based debouncer, registered rising-edge detect on the stable level.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any shorter excursion is forgotten.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    pulse_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/bcd_seg_counter.sv
// 4-digit BCD up/down/clear counter driven by conditioned push-buttons, with a
// registered 7-segment encoder and a start strobe whenever the display changes.
module bcd_seg_counter
  import seg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BLANK_LZ        = 1'b0
) (
  input  logic               Clk,
  input  logic               Rst,
  bcd_seg_counter_if.slave   bus
);

  localparam logic [7:0] SEG_LEAD_RST = BLANK_LZ ? SEG_BLANK : SEG_DIGIT[0];

  logic            up_p, dn_p, clr_p;
  logic [15:0]     count_q, count_d;
  logic [3:0][7:0] seg_q, seg_d;
  logic            start_q, start_d;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk_i(Clk), .rst_i(Rst), .btn_i(bus.UpB),   .pulse_o(up_p)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk_i(Clk), .rst_i(Rst), .btn_i(bus.DownB), .pulse_o(dn_p)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk_i(Clk), .rst_i(Rst), .btn_i(bus.ClrB),  .pulse_o(clr_p)
  );

  // Ripple a decimal carry/borrow from the units digit upward; wraps at both ends.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    bcd4_t       d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[i*4 +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) begin d = 4'd0; c = 1'b1; end
          else           begin d = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) begin d = 4'd9; c = 1'b1; end
          else           begin d = d - 4'd1; c = 1'b0; end
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  always_comb begin
    count_d = count_q;
    if (clr_p)              count_d = '0;
    else if (up_p && dn_p)  count_d = count_q;
    else if (up_p)          count_d = bcd_step(count_q, 1'b1);
    else if (dn_p)          count_d = bcd_step(count_q, 1'b0);
  end

  // Index 0 is the thousands digit; the units digit is never blanked.
  always_comb begin
    logic  zero_run;
    bcd4_t dig;
    seg_d    = seg_q;
    zero_run = BLANK_LZ;
    for (int i = 0; i < 4; i++) begin
      dig      = count_q[(3-i)*4 +: 4];
      zero_run = zero_run && (dig == 4'd0);
      if (zero_run && i < 3) seg_d[i] = SEG_BLANK;
      else                   seg_d[i] = seg_encode(dig);
    end
    start_d = (seg_d != seg_q);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q <= '0;
      seg_q   <= {SEG_DIGIT[0], SEG_LEAD_RST, SEG_LEAD_RST, SEG_LEAD_RST};
      start_q <= 1'b0;
    end else begin
      count_q <= count_d;
      seg_q   <= seg_d;
      start_q <= start_d;
    end
  end

  assign bus.Count = count_q;
  assign bus.seg0  = seg_q[0];
  assign bus.seg1  = seg_q[1];
  assign bus.seg2  = seg_q[2];
  assign bus.seg3  = seg_q[3];
  assign bus.start = start_q;

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Directed bench for bcd_seg_counter: stimulus pushes expected display updates
// into a queue, a monitor pops one on every start strobe and compares.
module tb_bcd_seg_counter;

  logic Clk;
  logic Rst;

  bcd_seg_counter_if bus();
  bcd_seg_counter_if bus_b();

  assign bus_b.UpB   = bus.UpB;
  assign bus_b.DownB = bus.DownB;
  assign bus_b.ClrB  = bus.ClrB;

  bcd_seg_counter #(.DEBOUNCE_CYCLES(4), .BLANK_LZ(1'b0)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus)
  );
  bcd_seg_counter #(.DEBOUNCE_CYCLES(4), .BLANK_LZ(1'b1)) dut_lz (
    .Clk(Clk), .Rst(Rst), .bus(bus_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] segs;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] model_segs(input logic [15:0] c);
    logic [7:0] tbl [10];
    logic [31:0] s;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    for (int i = 0; i < 4; i++) s[i*8 +: 8] = tbl[int'(c[i*4 +: 4])];
    return s;
  endfunction

  task automatic push_raw(input logic [15:0] c, input logic [31:0] s);
    exp_t e;
    e.cnt  = c;
    e.segs = s;
    exp_q.push_back(e);
  endtask

  task automatic press(input bit u, input bit d, input bit c);
    @(negedge Clk);
    bus.UpB = u; bus.DownB = d; bus.ClrB = c;
    repeat (10) @(negedge Clk);
    bus.UpB = 1'b0; bus.DownB = 1'b0; bus.ClrB = 1'b0;
    repeat (12) @(negedge Clk);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge Clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: %0d expected updates never seen", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] segs_a();
    return {bus.seg0, bus.seg1, bus.seg2, bus.seg3};
  endfunction

  function automatic logic [31:0] segs_b();
    return {bus_b.seg0, bus_b.seg1, bus_b.seg2, bus_b.seg3};
  endfunction

  // Monitor: Count must have moved exactly one edge before the start strobe.
  initial begin : monitor
    logic [15:0] h1, h2;
    exp_t e;
    h1 = '0;
    h2 = '0;
    forever begin
      @(negedge Clk);
      if (!Rst && bus.start) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_start: got start with Count=%h expected no update", bus.Count);
        end else begin
          e = exp_q.pop_front();
          check("update_count", 64'(bus.Count), 64'(e.cnt));
          check("update_segs",  64'(segs_a()),  64'(e.segs));
          check("update_latency", 64'((h1 == bus.Count) && (h2 != bus.Count)), 64'(1));
        end
      end
      h2 = h1;
      h1 = bus.Count;
    end
  end

  initial begin : stim
    int v;
    Rst = 1'b1;
    bus.UpB = 1'b0; bus.DownB = 1'b0; bus.ClrB = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_count", 64'(bus.Count), 64'h0000);
    check("reset_segs",  64'(segs_a()),  64'hC0C0C0C0);
    check("reset_start", 64'(bus.start), 64'(0));
    check("reset_segs_lz", 64'(segs_b()), 64'hFFFFFFC0);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);

    // clean press held 10 cycles
    push_raw(16'h0001, 32'hC0C0C0F9);
    press(1'b1, 1'b0, 1'b0);
    wait_drain("first_up");
    check("first_up_lz", 64'(segs_b()), 64'hFFFFFFF9);

    // one-cycle glitches must not register
    @(negedge Clk); bus.UpB = 1'b1;
    @(negedge Clk); bus.UpB = 1'b0;
    @(negedge Clk); bus.UpB = 1'b1;
    @(negedge Clk); bus.UpB = 1'b0;
    repeat (15) @(negedge Clk);
    check("bounce_count", 64'(bus.Count), 64'h0001);

    v = 1;
    while (v < 99) begin
      v++;
      push_raw(to_bcd(v), model_segs(to_bcd(v)));
      press(1'b1, 1'b0, 1'b0);
      wait_drain("climb_up");
    end
    check("count_0099", 64'(bus.Count), 64'h0099);

    push_raw(16'h0100, 32'hC0F9C0C0);
    press(1'b1, 1'b0, 1'b0);
    wait_drain("carry_0100");
    check("carry_0100_lz", 64'(segs_b()), 64'hFFF9C0C0);

    push_raw(16'h0000, 32'hC0C0C0C0);
    press(1'b0, 1'b0, 1'b1);
    wait_drain("clear");
    press(1'b0, 1'b0, 1'b1);
    check("clear_at_zero", 64'(bus.Count), 64'h0000);

    push_raw(16'h9999, 32'h90909090);
    press(1'b0, 1'b1, 1'b0);
    wait_drain("wrap_down");
    check("wrap_down_lz", 64'(segs_b()), 64'h90909090);

    push_raw(16'h0000, 32'hC0C0C0C0);
    press(1'b1, 1'b0, 1'b0);
    wait_drain("wrap_up");

    v = 0;
    while (v < 123) begin
      v++;
      push_raw(to_bcd(v), model_segs(to_bcd(v)));
      press(1'b1, 1'b0, 1'b0);
      wait_drain("climb_123");
    end
    check("count_0123_lz", 64'(segs_b()), 64'hFFF9A4B0);

    press(1'b1, 1'b1, 1'b0);
    check("up_down_hold", 64'(bus.Count), 64'h0123);

    push_raw(16'h0000, 32'hC0C0C0C0);
    press(1'b1, 1'b0, 1'b1);
    wait_drain("clr_over_up");

    push_raw(16'h0001, 32'hC0C0C0F9);
    press(1'b1, 1'b0, 1'b0);
    wait_drain("pre_reset_up");

    // reset while a held button is mid-debounce
    @(negedge Clk);
    bus.UpB = 1'b1;
    repeat (4) @(negedge Clk);
    #3 Rst = 1'b1;
    #1;
    check("midreset_count", 64'(bus.Count), 64'h0000);
    check("midreset_segs",  64'(segs_a()),  64'hC0C0C0C0);
    check("midreset_start", 64'(bus.start), 64'(0));
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    push_raw(16'h0001, 32'hC0C0C0F9);
    repeat (20) @(negedge Clk);
    bus.UpB = 1'b0;
    repeat (14) @(negedge Clk);
    wait_drain("held_after_reset");
    check("held_after_reset_count", 64'(bus.Count), 64'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
